// File: rtl/dcache_pkg.sv
// Shared types and constants for the N-way data-cache storage array.
// Holds the flush FSM encoding, default geometry and tag-field positions.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    EMIT,
    DONE
  } flush_state_t;

  localparam int DEF_WAYS   = 2;
  localparam int DEF_SETS   = 16;
  localparam int DEF_TAG_W  = 25;
  localparam int DEF_LINE_W = 256;

  // Tag word layout: {valid, dirty, address tag}
  function automatic int valid_bit(input int tag_w);
    return tag_w - 1;
  endfunction

  function automatic int dirty_bit(input int tag_w);
    return tag_w - 2;
  endfunction

endpackage

// File: rtl/dcache_lru_age.sv
// Combinational age-based true-LRU block for one cache set.
// Produces the post-touch age vector and the replacement victim.
module dcache_lru_age #(
  parameter int WAYS  = 2,
  parameter int WAY_W = $clog2(WAYS)
) (
  input  logic [WAYS-1:0][WAY_W-1:0] age,
  input  logic [WAY_W-1:0]           touched,
  input  logic [WAYS-1:0]            valid,
  output logic [WAYS-1:0][WAY_W-1:0] age_next,
  output logic [WAY_W-1:0]           victim
);

  logic [WAY_W-1:0] old_age;

  // Touched way becomes youngest; only ways younger than it age by one,
  // which keeps each set's ages a permutation of 0..WAYS-1.
  always_comb begin
    age_next = age;
    old_age  = age[touched];
    for (int w = 0; w < WAYS; w++) begin
      if (WAY_W'(w) == touched) begin
        age_next[w] = '0;
      end else if (age[w] < old_age) begin
        age_next[w] = age[w] + WAY_W'(1);
      end
    end
  end

  // An empty way is always preferred over evicting the oldest valid one.
  always_comb begin
    victim = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (age[w] == WAY_W'(WAYS - 1)) begin
        victim = WAY_W'(w);
      end
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid[w]) begin
        victim = WAY_W'(w);
      end
    end
  end

endmodule

// File: rtl/dcache_sram_nway.sv
// N-way set-associative data-cache storage with true LRU, victim read-out
// and a sequential dirty-line flush engine feeding the write-back path.
module dcache_sram_nway
  import dcache_pkg::*;
#(
  parameter int WAYS   = DEF_WAYS,
  parameter int SETS   = DEF_SETS,
  parameter int TAG_W  = DEF_TAG_W,
  parameter int LINE_W = DEF_LINE_W
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     enable_i,
  input  logic                     write_i,
  input  logic [$clog2(SETS)-1:0]  addr_i,
  input  logic [TAG_W-1:0]         tag_i,
  input  logic [LINE_W-1:0]        data_i,
  output logic [TAG_W-1:0]         tag_o,
  output logic [LINE_W-1:0]        data_o,
  output logic                     hit_o,
  output logic [$clog2(WAYS)-1:0]  hit_way_o,
  input  logic                     flush_i,
  output logic                     flush_busy_o,
  output logic                     flush_valid_o,
  input  logic                     flush_ready_i,
  output logic [$clog2(SETS)-1:0]  flush_set_o,
  output logic [TAG_W-1:0]         flush_tag_o,
  output logic [LINE_W-1:0]        flush_data_o,
  output logic                     flush_done_o
);

  localparam int SET_W     = $clog2(SETS);
  localparam int WAY_W     = $clog2(WAYS);
  localparam int VALID_BIT = valid_bit(TAG_W);
  localparam int DIRTY_BIT = dirty_bit(TAG_W);
  localparam int ADDR_W    = TAG_W - 2;

  logic [TAG_W-1:0]           tag_mem  [SETS][WAYS];
  logic [LINE_W-1:0]          data_mem [SETS][WAYS];
  logic [WAYS-1:0][WAY_W-1:0] age_mem  [SETS];

  flush_state_t state, state_next;
  logic [SET_W-1:0] scan_set;
  logic [WAY_W-1:0] scan_way;
  logic [TAG_W-1:0] scan_tag;
  logic             scan_dirty;
  logic             scan_last;
  logic             advance;
  logic             clear_dirty;

  logic                       busy;
  logic                       access;
  logic                       hit;
  logic [WAYS-1:0]            hit_vec;
  logic [WAYS-1:0]            valid_vec;
  logic [WAY_W-1:0]           hit_way;
  logic [WAY_W-1:0]           victim;
  logic [WAY_W-1:0]           sel_way;
  logic [WAYS-1:0][WAY_W-1:0] age_next;

  assign busy   = (state != IDLE);
  assign access = enable_i && !busy;

  // Tag compare ignores the request's valid/dirty bits; only stored valid counts.
  always_comb begin
    hit_vec   = '0;
    valid_vec = '0;
    for (int w = 0; w < WAYS; w++) begin
      valid_vec[w] = tag_mem[addr_i][w][VALID_BIT];
      hit_vec[w]   = valid_vec[w] &&
                     (tag_mem[addr_i][w][ADDR_W-1:0] == tag_i[ADDR_W-1:0]);
    end
  end

  always_comb begin
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (hit_vec[w]) begin
        hit_way = WAY_W'(w);
      end
    end
  end

  assign hit     = |hit_vec;
  assign sel_way = hit ? hit_way : victim;

  dcache_lru_age #(
    .WAYS  (WAYS),
    .WAY_W (WAY_W)
  ) u_lru (
    .age      (age_mem[addr_i]),
    .touched  (sel_way),
    .valid    (valid_vec),
    .age_next (age_next),
    .victim   (victim)
  );

  always_comb begin
    hit_o     = 1'b0;
    hit_way_o = '0;
    tag_o     = '0;
    data_o    = '0;
    if (access) begin
      hit_o     = hit;
      hit_way_o = sel_way;
      tag_o     = tag_mem[addr_i][sel_way];
      data_o    = data_mem[addr_i][sel_way];
    end
  end

  // Fills and write hits share one port; the flush only ever clears a dirty
  // bit, and never while an access can be accepted.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          tag_mem[s][w]  <= '0;
          data_mem[s][w] <= '0;
        end
      end
    end else begin
      if (access && write_i) begin
        tag_mem[addr_i][sel_way]  <= tag_i;
        data_mem[addr_i][sel_way] <= data_i;
      end
      if (clear_dirty) begin
        tag_mem[scan_set][scan_way][DIRTY_BIT] <= 1'b0;
      end
    end
  end

  // Read misses leave recency untouched so a probe cannot disturb eviction order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          age_mem[s][w] <= WAY_W'(w);
        end
      end
    end else if (access && (write_i || hit)) begin
      age_mem[addr_i] <= age_next;
    end
  end

  assign scan_tag   = tag_mem[scan_set][scan_way];
  assign scan_dirty = scan_tag[VALID_BIT] && scan_tag[DIRTY_BIT];
  assign scan_last  = (scan_set == SET_W'(SETS - 1)) && (scan_way == WAY_W'(WAYS - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    advance     = 1'b0;
    clear_dirty = 1'b0;
    case (state)
      IDLE: begin
        if (flush_i) begin
          state_next = SCAN;
        end
      end
      SCAN: begin
        if (scan_dirty) begin
          state_next = EMIT;
        end else begin
          advance = 1'b1;
          if (scan_last) begin
            state_next = DONE;
          end
        end
      end
      EMIT: begin
        if (flush_ready_i) begin
          clear_dirty = 1'b1;
          advance     = 1'b1;
          state_next  = scan_last ? DONE : SCAN;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Sweep cursor walks ways within a set before moving to the next set.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      scan_set <= '0;
      scan_way <= '0;
    end else if (state == IDLE) begin
      scan_set <= '0;
      scan_way <= '0;
    end else if (advance) begin
      if (scan_way == WAY_W'(WAYS - 1)) begin
        scan_way <= '0;
        scan_set <= scan_set + SET_W'(1);
      end else begin
        scan_way <= scan_way + WAY_W'(1);
      end
    end
  end

  assign flush_busy_o  = busy;
  assign flush_valid_o = (state == EMIT);
  assign flush_done_o  = (state == DONE);
  assign flush_set_o   = flush_valid_o ? scan_set : '0;
  assign flush_tag_o   = flush_valid_o ? scan_tag : '0;
  assign flush_data_o  = flush_valid_o ? data_mem[scan_set][scan_way] : '0;

endmodule

// File: tb/tb_dcache_sram_nway.sv
// Self-checking bench for dcache_sram_nway (4-way, 16 sets) against a
// recency-list reference model, plus directed literal scenarios.
module tb_dcache_sram_nway;

  localparam int WAYS   = 4;
  localparam int SETS   = 16;
  localparam int TAG_W  = 25;
  localparam int LINE_W = 256;
  localparam int SET_W  = 4;
  localparam int WAY_W  = 2;
  localparam int AT_W   = TAG_W - 2;
  localparam int NENT   = SETS * WAYS;

  logic              clk;
  logic              rst;
  logic              enable;
  logic              write;
  logic [SET_W-1:0]  addr;
  logic [TAG_W-1:0]  tag_in;
  logic [LINE_W-1:0] data_in;
  logic              flush;
  logic              ready;
  logic [TAG_W-1:0]  tag_o;
  logic [LINE_W-1:0] data_o;
  logic              hit_o;
  logic [WAY_W-1:0]  hit_way_o;
  logic              flush_busy_o;
  logic              flush_valid_o;
  logic [SET_W-1:0]  flush_set_o;
  logic [TAG_W-1:0]  flush_tag_o;
  logic [LINE_W-1:0] flush_data_o;
  logic              flush_done_o;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  // Reference model: contents plus a per-set recency list (MRU first).
  logic [TAG_W-1:0]  m_tag  [SETS][WAYS];
  logic [LINE_W-1:0] m_data [SETS][WAYS];
  int                m_order[SETS][WAYS];
  bit                m_busy;
  int                m_cursor;
  bit                m_seen;

  int                busy_cnt, done_cnt, emit_cnt, first_valid;
  logic [SET_W-1:0]  em_set [4];
  logic [TAG_W-1:0]  em_tag [4];

  dcache_sram_nway #(
    .WAYS(WAYS), .SETS(SETS), .TAG_W(TAG_W), .LINE_W(LINE_W)
  ) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .write_i(write),
    .addr_i(addr), .tag_i(tag_in), .data_i(data_in),
    .tag_o(tag_o), .data_o(data_o), .hit_o(hit_o), .hit_way_o(hit_way_o),
    .flush_i(flush), .flush_busy_o(flush_busy_o), .flush_valid_o(flush_valid_o),
    .flush_ready_i(ready), .flush_set_o(flush_set_o), .flush_tag_o(flush_tag_o),
    .flush_data_o(flush_data_o), .flush_done_o(flush_done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [TAG_W-1:0] mk_tag(input bit v, input bit d, input int t);
    logic [TAG_W-1:0] r;
    r = {v, d, AT_W'(t)};
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [LINE_W-1:0] act,
                             input logic [LINE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic report_timeout(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s actual=timeout required=completion", name);
  endtask

  task automatic model_reset();
    for (int s = 0; s < SETS; s++) begin
      for (int w = 0; w < WAYS; w++) begin
        m_tag[s][w]   = '0;
        m_data[s][w]  = '0;
        m_order[s][w] = w;
      end
    end
    m_busy   = 0;
    m_cursor = 0;
    m_seen   = 0;
  endtask

  task automatic touch(input int s, input int w);
    int p;
    p = 0;
    for (int i = 0; i < WAYS; i++) if (m_order[s][i] == w) p = i;
    for (int i = p; i > 0; i--) m_order[s][i] = m_order[s][i-1];
    m_order[s][0] = w;
  endtask

  task automatic model_find(input int s, input logic [TAG_W-1:0] t, output bit h, output int w);
    h = 0;
    w = -1;
    for (int i = 0; i < WAYS; i++) begin
      if (m_tag[s][i][TAG_W-1] && m_tag[s][i][AT_W-1:0] == t[AT_W-1:0]) begin
        h = 1;
        w = i;
      end
    end
    if (!h) begin
      for (int i = WAYS - 1; i >= 0; i--) if (!m_tag[s][i][TAG_W-1]) w = i;
      if (w < 0) w = m_order[s][WAYS-1];
    end
  endtask

  task automatic model_step();
    bit h;
    int w, s, fs, fw;
    s = int'(addr);
    if (!m_busy && enable) begin
      model_find(s, tag_in, h, w);
      if (write) begin
        m_tag[s][w]  = tag_in;
        m_data[s][w] = data_in;
        touch(s, w);
      end else if (h) begin
        touch(s, w);
      end
    end
    if (!m_busy) begin
      if (flush) begin
        m_busy   = 1;
        m_cursor = 0;
        m_seen   = 0;
      end
    end else if (m_cursor == NENT) begin
      m_busy = 0;
    end else begin
      fs = m_cursor / WAYS;
      fw = m_cursor % WAYS;
      if (m_tag[fs][fw][TAG_W-1] && m_tag[fs][fw][TAG_W-2]) begin
        if (!m_seen) begin
          m_seen = 1;
        end else if (ready) begin
          m_tag[fs][fw][TAG_W-2] = 1'b0;
          m_cursor++;
          m_seen = 0;
        end
      end else begin
        m_cursor++;
      end
    end
  endtask

  task automatic applyStimulus(input bit en, input bit wr, input int a,
                               input logic [TAG_W-1:0] t, input logic [LINE_W-1:0] d,
                               input bit fl, input bit rdy);
    enable  = en;
    write   = wr;
    addr    = SET_W'(a);
    tag_in  = t;
    data_in = d;
    flush   = fl;
    ready   = rdy;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    applyStimulus(0, 0, 0, '0, '0, 0, 0);
    step();
    step();
    rst = 1'b0;
  endtask

  // Drives one sweep; holds ready low for 'hold' cycles on the first line.
  task automatic run_flush(input int hold, input bit noise);
    int  hold_left;
    bit  rdy, pres;
    applyStimulus(0, 0, 0, '0, '0, 1, 1);
    step();
    busy_cnt = 0; done_cnt = 0; emit_cnt = 0; first_valid = 0;
    hold_left = hold;
    for (int c = 0; c < 1000; c++) begin
      if (!m_busy) break;
      pres = m_busy && m_cursor < NENT && m_seen;
      rdy  = 1;
      if (pres && emit_cnt == 0 && hold_left > 0) begin
        rdy = 0;
        hold_left--;
      end
      if (noise) applyStimulus(1, 1, 7, mk_tag(1, 1, 'h3f), {8{32'hdeadbeef}}, 0, rdy);
      else applyStimulus(0, 0, 0, '0, '0, 0, rdy);
      if (flush_busy_o) busy_cnt++;
      if (flush_valid_o && emit_cnt == 0) first_valid++;
      if (flush_valid_o && rdy && emit_cnt < 4) begin
        em_set[emit_cnt] = flush_set_o;
        em_tag[emit_cnt] = flush_tag_o;
        emit_cnt++;
      end
      if (flush_done_o) done_cnt++;
      step();
    end
    if (m_busy) report_timeout("flush_sweep");
  endtask

  // Every cycle, all outputs are compared with what the model says they must be.
  always @(negedge clk) begin : compare
    bit h, pres;
    int w, fs, fw;
    logic [TAG_W-1:0]  e_tag, e_ftag;
    logic [LINE_W-1:0] e_data, e_fdata;
    if (chk_en) begin
      h = 0; w = 0; e_tag = '0; e_data = '0;
      if (enable && !m_busy) begin
        model_find(int'(addr), tag_in, h, w);
        e_tag  = m_tag[addr][w];
        e_data = m_data[addr][w];
      end
      pres = m_busy && m_cursor < NENT && m_seen;
      fs = 0; fw = 0; e_ftag = '0; e_fdata = '0;
      if (pres) begin
        fs = m_cursor / WAYS;
        fw = m_cursor % WAYS;
        e_ftag  = m_tag[fs][fw];
        e_fdata = m_data[fs][fw];
      end
      checkOutput("hit_o", LINE_W'(hit_o), LINE_W'(h));
      checkOutput("hit_way_o", LINE_W'(hit_way_o), LINE_W'(w));
      checkOutput("tag_o", LINE_W'(tag_o), LINE_W'(e_tag));
      checkOutput("data_o", data_o, e_data);
      checkOutput("flush_busy_o", LINE_W'(flush_busy_o), LINE_W'(m_busy));
      checkOutput("flush_valid_o", LINE_W'(flush_valid_o), LINE_W'(pres));
      checkOutput("flush_set_o", LINE_W'(flush_set_o), LINE_W'(fs));
      checkOutput("flush_tag_o", LINE_W'(flush_tag_o), LINE_W'(e_ftag));
      checkOutput("flush_data_o", flush_data_o, e_fdata);
      checkOutput("flush_done_o", LINE_W'(flush_done_o),
                  LINE_W'(m_busy && m_cursor == NENT));
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [LINE_W-1:0] aa;
    bit found;
    aa = {(LINE_W/8){8'haa}};
    rst = 1'b0;
    applyStimulus(0, 0, 0, '0, '0, 0, 0);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk_en = 1;
    do_reset();

    // Reset state read
    applyStimulus(1, 0, 3, mk_tag(0, 0, 'h12), '0, 0, 0);
    checkOutput("rst_hit", LINE_W'(hit_o), '0);
    checkOutput("rst_way", LINE_W'(hit_way_o), '0);
    checkOutput("rst_tag", LINE_W'(tag_o), '0);
    checkOutput("rst_data", data_o, '0);
    step();

    // LRU replacement in set 5
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1, 1, 5, mk_tag(1, 0, k), {8{$urandom}}, 0, 0);
      step();
    end
    applyStimulus(1, 0, 5, mk_tag(1, 0, 1), '0, 0, 0);
    checkOutput("lru_read1_hit", LINE_W'(hit_o), LINE_W'(1));
    step();
    applyStimulus(1, 1, 5, mk_tag(1, 0, 5), {8{$urandom}}, 0, 0);
    checkOutput("lru_victim_way", LINE_W'(hit_way_o), LINE_W'(1));
    checkOutput("lru_victim_tag", LINE_W'(tag_o), LINE_W'(mk_tag(1, 0, 2)));
    step();
    applyStimulus(1, 0, 5, mk_tag(1, 0, 5), '0, 0, 0);
    checkOutput("lru_tag5_way", LINE_W'(hit_way_o), LINE_W'(1));
    step();
    applyStimulus(1, 0, 5, mk_tag(1, 0, 2), '0, 0, 0);
    checkOutput("lru_tag2_miss", LINE_W'(hit_o), '0);
    step();

    // Dirty write hit
    applyStimulus(1, 1, 2, mk_tag(1, 0, 7), {8{$urandom}}, 0, 0);
    step();
    applyStimulus(1, 1, 2, mk_tag(1, 1, 7), aa, 0, 0);
    step();
    applyStimulus(1, 0, 2, mk_tag(0, 0, 7), '0, 0, 0);
    checkOutput("wh_hit", LINE_W'(hit_o), LINE_W'(1));
    checkOutput("wh_data", data_o, aa);
    checkOutput("wh_dirty", LINE_W'(tag_o[TAG_W-2]), LINE_W'(1));
    step();

    // Two dirty lines, back-pressure on the first
    do_reset();
    applyStimulus(1, 1, 0, mk_tag(1, 0, 'h21), {8{$urandom}}, 0, 0); step();
    applyStimulus(1, 1, 0, mk_tag(1, 1, 'h22), {8{$urandom}}, 0, 0); step();
    applyStimulus(1, 1, 9, mk_tag(1, 1, 'h33), {8{$urandom}}, 0, 0); step();
    run_flush(3, 0);
    checkOutput("fl_busy_cycles", LINE_W'(busy_cnt), LINE_W'(70));
    checkOutput("fl_emits", LINE_W'(emit_cnt), LINE_W'(2));
    checkOutput("fl_first_hold", LINE_W'(first_valid), LINE_W'(4));
    checkOutput("fl_done", LINE_W'(done_cnt), LINE_W'(1));
    checkOutput("fl_set0", LINE_W'(em_set[0]), LINE_W'(0));
    checkOutput("fl_tag0", LINE_W'(em_tag[0]), LINE_W'(mk_tag(1, 1, 'h22)));
    checkOutput("fl_set1", LINE_W'(em_set[1]), LINE_W'(9));
    checkOutput("fl_tag1", LINE_W'(em_tag[1]), LINE_W'(mk_tag(1, 1, 'h33)));

    // Clean sweep with blocked accesses
    run_flush(0, 1);
    checkOutput("clean_busy_cycles", LINE_W'(busy_cnt), LINE_W'(NENT + 1));
    checkOutput("clean_emits", LINE_W'(emit_cnt), '0);
    checkOutput("clean_done", LINE_W'(done_cnt), LINE_W'(1));
    applyStimulus(1, 0, 7, mk_tag(1, 1, 'h3f), '0, 0, 0);
    checkOutput("busy_write_ignored", LINE_W'(hit_o), '0);
    step();

    // Reset during EMIT
    do_reset();
    applyStimulus(1, 1, 4, mk_tag(1, 1, 9), {8{$urandom}}, 0, 0); step();
    applyStimulus(0, 0, 0, '0, '0, 1, 0); step();
    found = 0;
    for (int c = 0; c < 200; c++) begin
      if (m_busy && m_seen) begin
        found = 1;
        break;
      end
      applyStimulus(0, 0, 0, '0, '0, 0, 0);
      step();
    end
    if (!found) report_timeout("reach_emit");
    checkOutput("pre_rst_valid", LINE_W'(flush_valid_o), LINE_W'(1));
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    checkOutput("rst_async_valid", LINE_W'(flush_valid_o), '0);
    checkOutput("rst_async_busy", LINE_W'(flush_busy_o), '0);
    step();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      applyStimulus(1, 0, 4, mk_tag(1, 1, 9), '0, 0, 0);
      checkOutput("post_rst_miss", LINE_W'(hit_o), '0);
      checkOutput("post_rst_nodone", LINE_W'(flush_done_o), '0);
      step();
    end

    // Randomised traffic with occasional sweeps
    do_reset();
    for (int c = 0; c < 900; c++) begin
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                    ($urandom_range(0, 3) == 0) ? $urandom_range(0, SETS - 1) : $urandom_range(0, 2),
                    mk_tag($urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1,
                           $urandom_range(0, 5)),
                    {8{$urandom}}, $urandom_range(0, 49) == 0, $urandom_range(0, 1) == 1);
      step();
    end
    found = 0;
    for (int c = 0; c < 500; c++) begin
      if (!m_busy) begin
        found = 1;
        break;
      end
      applyStimulus(0, 0, 0, '0, '0, 0, 1);
      step();
    end
    if (!found) report_timeout("random_drain");

    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
